// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared console types and constants for the OAM DMA engine.
package oam_dma_pkg;
    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} oam_dma_state_t;
    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam int          OAM_BYTES = 160;
    localparam int          START_DLY = 1;
    function automatic logic [7:0] echo_fold(input logic [7:0] hi);
        return hi >= 8'hE0 ? hi - 8'h20 : hi;
    endfunction
endpackage

// File: rtl/oam_dma.sv
// oam_dma: FF46 OAM DMA engine, copies 160 bytes from XX00-XX9F into OAM one byte per M-cycle.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        dma_reg_target,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  dma_reg_rdata,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_waddr,
    output logic [7:0]  oam_wdata,
    output logic        oamdma
);
    oam_dma_state_t state_q, state_d;
    logic [7:0]  idx_q, idx_d, src_hi_q, src_hi_d, reg_q, reg_d;
    logic [1:0]  dly_q, dly_d;
    logic        restart_q, restart_d, accept, last;
    logic [15:0] addr_q;

    always_comb begin
        accept    = cpu_en & cpu_wr & dma_reg_target;
        last      = idx_q == 8'(OAM_BYTES - 1);
        state_d   = state_q;
        idx_d     = idx_q;
        src_hi_d  = src_hi_q;
        reg_d     = reg_q;
        dly_d     = dly_q;
        restart_d = restart_q;
        if (cpu_en && state_q == DMA_START) begin
            if (dly_q == 2'd0) begin
                state_d = DMA_XFER;
                idx_d   = 8'd0;
            end else
                dly_d = dly_q - 2'd1;
        end
        if (cpu_en && state_q == DMA_XFER) begin
            idx_d   = last ? idx_q : idx_q + 8'd1;
            state_d = last ? DMA_IDLE : DMA_XFER;
        end
        // An accept overrides the above; the current byte is still strobed this M-cycle
        if (accept) begin
            state_d   = DMA_START;
            dly_d     = 2'(START_DLY - 1);
            src_hi_d  = echo_fold(cpu_wdata);
            reg_d     = cpu_wdata;
            restart_d = (state_q == DMA_XFER) | (state_q == DMA_START & restart_q);
        end
    end

    assign dma_addr      = state_q == DMA_XFER ? {src_hi_q, idx_q} : addr_q;
    assign oam_we        = (state_q == DMA_XFER) & cpu_en;
    assign oam_waddr     = idx_q;
    assign oam_wdata     = dma_rdata;
    assign oamdma        = (state_q == DMA_XFER) | (state_q == DMA_START & restart_q);
    assign dma_reg_rdata = reg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            idx_q     <= 8'd0;
            src_hi_q  <= 8'd0;
            reg_q     <= 8'hFF;
            dly_q     <= 2'd0;
            restart_q <= 1'b0;
            addr_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            src_hi_q  <= src_hi_d;
            reg_q     <= reg_d;
            dly_q     <= dly_d;
            restart_q <= restart_d;
            addr_q    <= dma_addr;
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed, table-driven checks of the OAM DMA engine against hand-derived expectations.
module tb_oam_dma;
    logic        clk = 0, reset = 1, cpu_en = 0, dma_reg_target = 0, cpu_wr = 0;
    logic [7:0]  cpu_wdata = 0, dma_reg_rdata, dma_rdata, oam_waddr, oam_wdata;
    logic [15:0] dma_addr;
    logic        oam_we, oamdma;
    logic        s_we, s_dma;
    logic [7:0]  s_waddr, s_wdata;
    logic [15:0] s_addr;
    int          total = 0, passed = 0;

    oam_dma dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .dma_reg_target(dma_reg_target),
        .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .dma_reg_rdata(dma_reg_rdata),
        .dma_addr(dma_addr), .dma_rdata(dma_rdata), .oam_we(oam_we),
        .oam_waddr(oam_waddr), .oam_wdata(oam_wdata), .oamdma(oamdma)
    );

    always #5 clk = ~clk;
    assign dma_rdata = dma_addr[15:8] ^ dma_addr[7:0] ^ 8'h5A;

    typedef struct {
        logic [7:0] wr;
        logic [7:0] hi;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input logic wr, input logic [7:0] d);
        @(negedge clk);
        cpu_en = 1; cpu_wr = wr; dma_reg_target = wr; cpu_wdata = d;
        #1;
        s_we = oam_we; s_dma = oamdma; s_waddr = oam_waddr; s_wdata = oam_wdata; s_addr = dma_addr;
        @(posedge clk);
        #1;
        cpu_en = 0; cpu_wr = 0; dma_reg_target = 0;
        @(posedge clk);
    endtask

    task automatic run_copy(input logic [7:0] hi, input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            logic [15:0] a;
            a = {hi, 8'(i)};
            tick(0, 8'h00);
            chk($sformatf("byte %0d from %h", i, a),
                {30'd0, s_we, s_dma, s_waddr, s_addr, s_wdata},
                {30'd0, 1'b1, 1'b1, 8'(i), a, mem(a)});
        end
    endtask

    task automatic start(input logic [7:0] d, input logic exp_dma);
        tick(1, d);
        chk("accept cycle we", {63'd0, s_we}, 64'd0);
        tick(0, 8'h00);
        chk("start cycle we/oamdma", {62'd0, s_we, s_dma}, {62'd0, 1'b0, exp_dma});
    endtask

    initial begin
        vecs[0] = '{8'hC1, 8'hC1};
        vecs[1] = '{8'hE3, 8'hC3};
        vecs[2] = '{8'hDF, 8'hDF};
        vecs[3] = '{8'hE0, 8'hC0};
        vecs[4] = '{8'hFF, 8'hDF};
        vecs[5] = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 0;
        #1;
        chk("reset reg", {56'd0, dma_reg_rdata}, 64'hFF);
        chk("reset addr", {48'd0, dma_addr}, 64'h0);
        chk("reset we/oamdma", {62'd0, oam_we, oamdma}, 64'd0);

        foreach (vecs[k]) begin
            start(vecs[k].wr, 1'b0);
            chk($sformatf("reg after write %h", vecs[k].wr), {56'd0, dma_reg_rdata}, {56'd0, vecs[k].wr});
            run_copy(vecs[k].hi, 0, 159);
            tick(0, 8'h00);
            chk("post-copy we/oamdma", {62'd0, s_we, s_dma}, 64'd0);
            chk("post-copy addr hold", {48'd0, s_addr}, {48'd0, vecs[k].hi, 8'h9F});
        end

        start(8'h80, 1'b0);
        run_copy(8'h80, 0, 49);
        tick(1, 8'hC0);
        chk("restart byte 50", {30'd0, s_we, s_dma, s_waddr, s_addr, s_wdata},
            {30'd0, 1'b1, 1'b1, 8'd50, 16'h8032, mem(16'h8032)});
        tick(0, 8'h00);
        chk("restart start oamdma/we", {62'd0, s_dma, s_we}, {62'd0, 1'b1, 1'b0});
        run_copy(8'hC0, 0, 159);
        tick(0, 8'h00);
        chk("restart done oamdma", {63'd0, s_dma}, 64'd0);

        start(8'h40, 1'b0);
        run_copy(8'h40, 0, 99);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        chk("mid-xfer reset oamdma", {63'd0, oamdma}, 64'd0);
        chk("mid-xfer reset reg", {56'd0, dma_reg_rdata}, 64'hFF);
        chk("mid-xfer reset addr", {48'd0, dma_addr}, 64'h0);
        @(negedge clk) reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 8'h00);
            chk("no we after reset", {62'd0, s_we, s_dma}, 64'd0);
        end

        start(8'h55, 1'b0);
        run_copy(8'h55, 0, 19);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("gated we/oamdma", {62'd0, oam_we, oamdma}, {62'd0, 1'b0, 1'b1});
            chk("gated addr hold", {48'd0, dma_addr}, 64'h5514);
        end
        run_copy(8'h55, 20, 159);

        start(8'h33, 1'b0);
        run_copy(8'h33, 0, 158);
        tick(1, 8'h12);
        chk("last byte with accept", {30'd0, s_we, s_dma, s_waddr, s_addr, s_wdata},
            {30'd0, 1'b1, 1'b1, 8'd159, 16'h339F, mem(16'h339F)});
        tick(0, 8'h00);
        chk("last-byte restart oamdma/we", {62'd0, s_dma, s_we}, {62'd0, 1'b1, 1'b0});
        run_copy(8'h12, 0, 159);
        tick(0, 8'h00);
        chk("final idle oamdma", {63'd0, s_dma}, 64'd0);
        chk("final reg", {56'd0, dma_reg_rdata}, 64'h12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
